// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - column-serial forward AES MixColumns engine with per-block bypass
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic         byp_q, byp_d;
    logic [127:0] in_q, in_d;
    logic [127:0] res_q, res_d;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        r0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        r3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    always_comb begin
        col_in = in_q[127:96];
        case (col_q)
            2'd0: col_in = in_q[127:96];
            2'd1: col_in = in_q[95:64];
            2'd2: col_in = in_q[63:32];
            2'd3: col_in = in_q[31:0];
            default: col_in = in_q[127:96];
        endcase
        col_out = byp_q ? col_in : mix_col(col_in);
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        byp_d   = byp_q;
        in_d    = in_q;
        res_d   = res_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_d    = state_in;
                    byp_d   = bypass;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                case (col_q)
                    2'd0: res_d[127:96] = col_out;
                    2'd1: res_d[95:64]  = col_out;
                    2'd2: res_d[63:32]  = col_out;
                    2'd3: res_d[31:0]   = col_out;
                    default: res_d = res_q;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            byp_q   <= 1'b0;
            in_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            byp_q   <= byp_d;
            in_q    <= in_d;
            res_q   <= res_d;
        end
    end

    // Handshake outputs depend on registered state only.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign state_out = res_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - randomized self-checking bench for mix_columns_seq
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] state_in = '0;
    logic         bypass = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] state_out;
    logic         busy;

    mix_columns_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .state_in(state_in), .bypass(bypass), .out_valid(out_valid),
        .out_ready(out_ready), .state_out(state_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_xfer = 0;
    logic [127:0] last_xfer = '0;
    logic [127:0] last_out = '0;
    bit prev_rst_low = 1'b0;

    typedef struct {
        logic [127:0] din;
        logic         byp;
        logic [127:0] exp;
        int           acc;
    } blk_t;
    blk_t q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Field multiply by shift-and-add, independent of any xtime unrolling.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] coef(input bit inv, input int d);
        case (d)
            0: coef = inv ? 8'd14 : 8'd2;
            1: coef = inv ? 8'd11 : 8'd3;
            2: coef = inv ? 8'd13 : 8'd1;
            default: coef = inv ? 8'd9 : 8'd1;
        endcase
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
        logic [127:0] r;
        logic [7:0] acc;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef(inv, (j - i + 4) % 4), s[127 - 32*c - 8*j -: 8]);
                r[127 - 32*c - 8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit exp_valid, exp_busy, exp_ready;
        blk_t b;
        if (!rst_n) begin
            if (prev_rst_low) begin
                chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
                chk("rst_busy", {127'd0, busy}, 128'd0);
                chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
                chk("rst_state_out", state_out, 128'd0);
            end
            q.delete();
            last_out = '0;
            prev_rst_low = 1'b1;
        end else begin
            prev_rst_low = 1'b0;
            exp_ready = (q.size() == 0);
            exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 5);
            exp_busy  = (q.size() > 0) && (cyc >= q[0].acc + 1) && (cyc <= q[0].acc + 4);
            chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ready});
            chk("out_valid", {127'd0, out_valid}, {127'd0, exp_valid});
            chk("busy", {127'd0, busy}, {127'd0, exp_busy});
            if (exp_ready) chk("held_out", state_out, last_out);
            if (exp_valid) chk("state_out", state_out, q[0].exp);
            if (exp_ready && in_valid) begin
                b.din = state_in;
                b.byp = bypass;
                b.exp = bypass ? state_in : mix_model(state_in, 1'b0);
                b.acc = cyc;
                q.push_back(b);
                n_acc++;
            end
            if (exp_valid && out_ready) begin
                b = q.pop_front();
                if (b.byp) chk("bypass_equal", state_out, b.din);
                else chk("inv_recover", mix_model(state_out, 1'b1), b.din);
                last_xfer = state_out;
                last_out = b.exp;
                n_xfer++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d, input logic byp);
        int guard;
        state_in = d;
        bypass = byp;
        in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            n_err++;
            $display("FAIL send_timeout: in_ready stayed low");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_xfer();
        int start;
        int guard;
        start = n_xfer;
        guard = 0;
        while (n_xfer == start && guard < 50) begin
            tick();
            guard++;
        end
        if (n_xfer == start) begin
            n_err++;
            $display("FAIL xfer_timeout: no output transfer");
        end
    endtask

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] V3_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        int base;
        int guard;
        chk("model_v1", mix_model(V1_IN, 1'b0), V1_OUT);
        chk("model_v2", mix_model(V2_IN, 1'b0), V2_OUT);
        chk("model_inv", mix_model(V1_OUT, 1'b1), V1_IN);

        // Reset held with in_valid high, then accept on the first edge after release.
        rst_n = 1'b0;
        in_valid = 1'b1;
        state_in = V1_IN;
        bypass = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("accept_first_edge", {127'd0, busy}, 128'd1);
        wait_xfer();
        chk("fips_v1", last_xfer, V1_OUT);

        send(V2_IN, 1'b0);
        wait_xfer();
        chk("fips_v2", last_xfer, V2_OUT);

        send(V3_IN, 1'b1);
        wait_xfer();
        chk("bypass_lit", last_xfer, V3_IN);

        // Backpressure with input noise while the result is held.
        out_ready = 1'b0;
        send(V2_IN, 1'b0);
        guard = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = $urandom_range(0, 1) == 1;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            bypass = $urandom_range(0, 1) == 1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_xfer();
        chk("stall_v2", last_xfer, V2_OUT);

        // Reset during the second BUSY cycle aborts the block.
        send(V1_IN, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", {127'd0, busy}, 128'd0);
        chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
        repeat (8) tick();
        send(V2_IN, 1'b0);
        wait_xfer();
        chk("after_abort", last_xfer, V2_OUT);

        base = n_acc;
        guard = 0;
        while (n_acc < base + 1000 && guard < 40000) begin
            out_ready = $urandom_range(0, 3) != 0;
            in_valid = $urandom_range(0, 3) != 0;
            state_in = {$urandom, $urandom, $urandom, $urandom};
            bypass = $urandom_range(0, 7) == 0;
            tick();
            guard++;
        end
        if (n_acc < base + 1000) begin
            n_err++;
            $display("FAIL random_timeout: only %0d blocks accepted", n_acc - base);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        chk("drained", {96'd0, 32'(q.size())}, 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
